kb_action_scheduler: RTL and testbench

//  Turns debounced keyboard levels into discrete game actions for the Tetris core.
//  Per key: press edge detect, delayed auto-repeat (DAS/ARR) and one pending-action flag.
//  A round-robin arbiter shares a single action port among all keys, using a valid/ready handshake.

---
 rtl/kb_action_scheduler.sv | 177 +++++++++++++++++
 tb/tb_kb_action_scheduler.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/kb_action_scheduler.sv
// Keyboard action scheduler: per-key press/DAS/ARR FSMs feeding a round-robin
// arbiter that presents one action at a time over a valid/ready port.

module kb_key_fsm #(
  parameter int DAS_TICKS  = 30,
  parameter int ARR_TICKS  = 6,
  parameter bit CAN_REPEAT = 1'b1,
  parameter int CW         = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic level,
  input  logic grant,
  output logic pending,
  output logic rep_flag,
  output logic held
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_PRESS  = 2'd1;
  localparam logic [1:0] S_REPEAT = 2'd2;

  logic [1:0]    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          set, rep_n;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    set     = 1'b0;
    rep_n   = rep_flag;
    if (tick) begin
      case (state)
        S_IDLE: if (level) begin
          state_n = S_PRESS;
          set     = 1'b1;
          rep_n   = 1'b0;
          cnt_n   = CW'(DAS_TICKS);
        end
        S_PRESS: begin
          if (!level) state_n = S_IDLE;
          // a non-repeating key parks here with cnt frozen at 0
          else if (cnt != '0) begin
            if (cnt == CW'(1)) begin
              if (CAN_REPEAT) begin
                state_n = S_REPEAT;
                set     = 1'b1;
                rep_n   = 1'b1;
                cnt_n   = CW'(ARR_TICKS);
              end else begin
                cnt_n = '0;
              end
            end else begin
              cnt_n = cnt - 1'b1;
            end
          end
        end
        S_REPEAT: begin
          if (!level) state_n = S_IDLE;
          else if (cnt <= CW'(1)) begin
            set   = 1'b1;
            rep_n = 1'b1;
            cnt_n = CW'(ARR_TICKS);
          end else begin
            cnt_n = cnt - 1'b1;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      pending  <= 1'b0;
      rep_flag <= 1'b0;
      held     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      rep_flag <= rep_n;
      held     <= (state_n != S_IDLE);
      // a new set beats a same-cycle grant clear
      pending  <= set | (pending & ~grant);
    end
  end
endmodule

module kb_action_scheduler #(
  parameter int                    NUM_KEYS    = 8,
  parameter int                    SAMPLE_DIV  = 250000,
  parameter int                    DAS_TICKS   = 30,
  parameter int                    ARR_TICKS   = 6,
  parameter logic [NUM_KEYS-1:0]   REPEAT_MASK = 8'b0000_1011
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_KEYS-1:0]         keys_in,
  output logic                        act_valid,
  input  logic                        act_ready,
  output logic [$clog2(NUM_KEYS)-1:0] act_code,
  output logic                        act_repeat,
  output logic [NUM_KEYS-1:0]         held
);
  localparam int AW      = $clog2(NUM_KEYS);
  localparam int DW      = $clog2(SAMPLE_DIV);
  localparam int CNT_MAX = (DAS_TICKS > ARR_TICKS) ? DAS_TICKS : ARR_TICKS;
  localparam int CW      = $clog2(CNT_MAX + 1);

  logic [DW-1:0]       div;
  logic                tick;
  logic [NUM_KEYS-1:0] pending, rep_flag, grant;
  logic [AW-1:0]       rr_ptr, winner;
  logic                found, load;

  assign tick = (div == DW'(SAMPLE_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) div <= '0;
    else     div <= tick ? '0 : div + 1'b1;
  end

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    kb_key_fsm #(
      .DAS_TICKS (DAS_TICKS),
      .ARR_TICKS (ARR_TICKS),
      .CAN_REPEAT(REPEAT_MASK[g]),
      .CW        (CW)
    ) u_key (
      .clk     (clk),
      .rst     (rst),
      .tick    (tick),
      .level   (keys_in[g]),
      .grant   (grant[g]),
      .pending (pending[g]),
      .rep_flag(rep_flag[g]),
      .held    (held[g])
    );
  end

  assign load = !act_valid || act_ready;

  // first pending index at or after rr_ptr, wrapping
  always_comb begin
    int idx;
    found  = 1'b0;
    winner = '0;
    grant  = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_KEYS) idx = idx - NUM_KEYS;
      if (!found && pending[idx]) begin
        found  = 1'b1;
        winner = AW'(idx);
      end
    end
    if (load && found) grant[winner] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      act_valid  <= 1'b0;
      act_code   <= '0;
      act_repeat <= 1'b0;
      rr_ptr     <= '0;
    end else if (load) begin
      act_valid <= found;
      if (found) begin
        act_code   <= winner;
        act_repeat <= rep_flag[winner];
        rr_ptr     <= (winner == AW'(NUM_KEYS - 1)) ? '0 : winner + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_kb_action_scheduler.sv
// Randomized + directed bench for kb_action_scheduler against a tick-count
// reference model of key actions and round-robin arbitration.

module tb_kb_action_scheduler;
  localparam int N = 8, SD = 4, DAS = 3, ARR = 2;
  localparam logic [7:0] MASK = 8'b0000_1011;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       act_ready = 1'b1;
  logic [7:0] keys_in = '0;
  logic       act_valid, act_repeat;
  logic [2:0] act_code;
  logic [7:0] held;

  kb_action_scheduler #(
    .NUM_KEYS(N), .SAMPLE_DIV(SD), .DAS_TICKS(DAS), .ARR_TICKS(ARR), .REPEAT_MASK(MASK)
  ) dut (
    .clk(clk), .rst(rst), .keys_in(keys_in), .act_valid(act_valid),
    .act_ready(act_ready), .act_code(act_code), .act_repeat(act_repeat), .held(held)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_chk = 0;

  // model: held-tick count per key decides when an action is due
  int m_div, m_ptr, m_code;
  int m_hcnt[N];
  bit m_held[N], m_pend[N], m_rep[N];
  bit m_valid, m_repeat;

  // DUT handshakes observed, {repeat, code}
  logic [3:0] acts[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_step();
    bit tck, found;
    int w, idx;
    if (rst) begin
      m_div = 0; m_ptr = 0; m_code = 0; m_valid = 0; m_repeat = 0;
      for (int i = 0; i < N; i++) begin
        m_hcnt[i] = 0; m_held[i] = 0; m_pend[i] = 0; m_rep[i] = 0;
      end
      return;
    end
    tck   = (m_div == SD - 1);
    m_div = (m_div + 1) % SD;
    if (!m_valid || act_ready) begin
      found = 0; w = 0;
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (!found && m_pend[idx]) begin found = 1; w = idx; end
      end
      if (found) begin
        m_valid = 1; m_code = w; m_repeat = m_rep[w];
        m_pend[w] = 0; m_ptr = (w + 1) % N;
      end else m_valid = 0;
    end
    if (tck) begin
      for (int i = 0; i < N; i++) begin
        if (keys_in[i]) begin
          if (m_hcnt[i] == 0) begin m_pend[i] = 1; m_rep[i] = 0; end
          else if (MASK[i] && m_hcnt[i] >= DAS && (m_hcnt[i] - DAS) % ARR == 0) begin
            m_pend[i] = 1; m_rep[i] = 1;
          end
          m_held[i] = 1; m_hcnt[i]++;
        end else begin
          m_held[i] = 0; m_hcnt[i] = 0;
        end
      end
    end
  endtask

  task automatic cyc();
    logic [7:0] mh;
    if (act_valid && act_ready && !rst) acts.push_back({act_repeat, act_code});
    @(posedge clk);
    model_step();
    #1;
    for (int i = 0; i < N; i++) mh[i] = m_held[i];
    chk("act_valid", act_valid, m_valid);
    chk("act_code", act_code, m_code);
    chk("act_repeat", act_repeat, m_repeat);
    chk("held", held, mh);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  // after this, the SD-th following edge is a tick edge
  task automatic align();
    while (m_div != 0) cyc();
  endtask

  task automatic do_reset();
    rst = 1'b1; run(2); rst = 1'b0;
  endtask

  task automatic tap_ticks(input logic [7:0] k, input int ticks);
    align(); keys_in = k; run(SD * ticks); keys_in = '0;
  endtask

  initial begin
    // reset with all keys held
    keys_in = 8'hFF; run(3);
    rst = 1'b0; keys_in = '0; run(8);

    // tap
    acts.delete();
    tap_ticks(8'h01, 1); run(SD * 3);
    chk("tap_count", acts.size(), 1);
    if (acts.size() > 0) chk("tap_act", acts[0], 4'h0);

    // auto-repeat key1, 12 ticks
    acts.delete();
    tap_ticks(8'h02, 12); run(SD * 6);
    chk("arr_count", acts.size(), 6);
    if (acts.size() == 6) begin
      chk("arr_first", acts[0], 4'h1);
      for (int i = 1; i < 6; i++) chk("arr_rep", acts[i], 4'h9);
    end

    // non-repeating key2, 20 ticks
    acts.delete();
    tap_ticks(8'h04, 20); run(SD * 3);
    chk("norep_count", acts.size(), 1);

    // round-robin from rr_ptr=0
    do_reset(); acts.delete();
    align(); keys_in = 8'h29; act_ready = 1'b0;
    run(SD); keys_in = '0; run(10 - SD);
    act_ready = 1'b1; run(SD * 3);
    chk("rr0_count", acts.size(), 3);
    if (acts.size() == 3) begin
      chk("rr0_a", acts[0], 4'h0); chk("rr0_b", acts[1], 4'h3); chk("rr0_c", acts[2], 4'h5);
    end

    // tap key3 to move rr_ptr to 4, then same burst
    tap_ticks(8'h08, 1); run(SD * 2);
    acts.delete();
    align(); keys_in = 8'h29; act_ready = 1'b0;
    run(SD); keys_in = '0; run(10 - SD);
    act_ready = 1'b1; run(SD * 3);
    chk("rr4_count", acts.size(), 3);
    if (acts.size() == 3) begin
      chk("rr4_a", acts[0], 4'h5); chk("rr4_b", acts[1], 4'h0); chk("rr4_c", acts[2], 4'h3);
    end

    // merge: key3 occupies the port, key1 press then repeat merge while stalled
    do_reset(); acts.delete();
    act_ready = 1'b0;
    tap_ticks(8'h08, 1);
    keys_in = 8'h02; run(SD * 4); keys_in = '0;
    run(SD); act_ready = 1'b1; run(SD * 3);
    chk("merge_count", acts.size(), 2);
    if (acts.size() == 2) begin
      chk("merge_a", acts[0], 4'h3); chk("merge_b", acts[1], 4'h9);
    end

    // reset while an action is offered
    acts.delete(); act_ready = 1'b0;
    tap_ticks(8'h10, 1);
    begin
      int budget = 20;
      while (!act_valid && budget > 0) begin cyc(); budget--; end
      chk("offer_seen", act_valid, 1'b1);
    end
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("rst_drop", act_valid, 1'b0);
    act_ready = 1'b1; run(SD * 4);
    chk("rst_lost", acts.size(), 0);

    // random traffic
    for (int t = 0; t < 250; t++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(3) == 0) keys_in[b] = ~keys_in[b];
      for (int c = 0; c < SD; c++) begin
        act_ready = ($urandom_range(9) < 7);
        rst = ($urandom_range(299) == 0);
        cyc();
      end
    end
    rst = 1'b0; keys_in = '0; act_ready = 1'b1; run(SD * 4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
